// File: rtl/alu_pkg.sv
// Shared definitions for the ALU command sequencer: op-codes and FSM encoding.
package alu_pkg;

    // ALU operation codes carried on cmd_op / alu_select.
    localparam logic [2:0] OP_ADD     = 3'b000;
    localparam logic [2:0] OP_SUB     = 3'b001;
    localparam logic [2:0] OP_NOT     = 3'b010;
    localparam logic [2:0] OP_AND     = 3'b011;
    localparam logic [2:0] OP_OR      = 3'b100;
    localparam logic [2:0] OP_XOR     = 3'b101;
    localparam logic [2:0] OP_CMP     = 3'b110;
    localparam logic [2:0] OP_ILLEGAL = 3'b111;

    // Sequencer states: accept a command, let the ALU settle, hold the response.
    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_EXEC = 2'b01,
        ST_RESP = 2'b10
    } state_t;

    // Every code except the reserved all-ones pattern drives a real ALU operation.
    function automatic logic is_legal(input logic [2:0] op);
        return op != OP_ILLEGAL;
    endfunction

endpackage

// File: rtl/alu_sequencer.sv
// Sequences one command at a time through an external combinational ALU:
// registers the operands, samples the result one cycle later, holds it until
// consumed, and keeps a count of legal operations plus a sticky overflow flag.
//
// Handshakes: a transfer happens on a rising clock edge where valid and ready
// are both high. cmd_ready is high only in IDLE; rsp_valid is high only in
// RESP, and all rsp_* are stable while rsp_valid is high and rsp_ready is low.
module alu_sequencer
    import alu_pkg::*;
#(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [2:0]       cmd_op,
    input  logic             cmd_c,
    input  logic [3:0]       cmd_x,
    input  logic [3:0]       cmd_y,
    output logic [2:0]       alu_select,
    output logic             alu_in_c,
    output logic [3:0]       alu_in_x,
    output logic [3:0]       alu_in_y,
    input  logic [3:0]       alu_out_s,
    input  logic             alu_out_c,
    input  logic             alu_overflow,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [3:0]       rsp_s,
    output logic             rsp_c,
    output logic             rsp_zero,
    output logic             rsp_ovf,
    output logic             rsp_err,
    input  logic             clr,
    output logic             sticky_ovf,
    output logic [CNT_W-1:0] op_count,
    output state_t           state
);

    state_t state_next;
    logic   accept;
    logic   finish_exec;
    logic   legal_exec;

    // Next-state logic and handshake outputs derived from the current state.
    always_comb begin
        state_next  = state;
        cmd_ready   = 1'b0;
        rsp_valid   = 1'b0;
        accept      = 1'b0;
        finish_exec = 1'b0;
        case (state)
            ST_IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) begin
                    accept     = 1'b1;
                    state_next = ST_EXEC;
                end
            end
            ST_EXEC: begin
                finish_exec = 1'b1;
                state_next  = ST_RESP;
            end
            ST_RESP: begin
                rsp_valid = 1'b1;
                // Returning to IDLE costs a full cycle, so no command can be
                // taken on the same edge that the response is consumed.
                if (rsp_ready) begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    assign legal_exec = finish_exec && is_legal(alu_select);

    // State register; reset abandons any command in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // ALU drive registers: loaded only on acceptance, otherwise held.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alu_select <= 3'b000;
            alu_in_c   <= 1'b0;
            alu_in_x   <= 4'h0;
            alu_in_y   <= 4'h0;
        end else if (accept) begin
            alu_select <= cmd_op;
            alu_in_c   <= cmd_c;
            alu_in_x   <= cmd_x;
            alu_in_y   <= cmd_y;
        end
    end

    // Response registers: captured from the ALU at the end of EXEC only, so
    // they stay frozen for the whole of RESP regardless of rsp_ready.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_s    <= 4'h0;
            rsp_c    <= 1'b0;
            rsp_zero <= 1'b0;
            rsp_ovf  <= 1'b0;
            rsp_err  <= 1'b0;
        end else if (finish_exec) begin
            if (is_legal(alu_select)) begin
                rsp_s    <= alu_out_s;
                rsp_c    <= alu_out_c;
                // Zero is computed here rather than trusted from the ALU.
                rsp_zero <= (alu_out_s == 4'h0);
                rsp_ovf  <= alu_overflow;
                rsp_err  <= 1'b0;
            end else begin
                rsp_s    <= 4'h0;
                rsp_c    <= 1'b0;
                rsp_zero <= 1'b0;
                rsp_ovf  <= 1'b0;
                rsp_err  <= 1'b1;
            end
        end
    end

    // Status counters: clr wins over a simultaneous count/overflow update.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_count   <= '0;
            sticky_ovf <= 1'b0;
        end else if (clr) begin
            op_count   <= '0;
            sticky_ovf <= 1'b0;
        end else if (legal_exec) begin
            op_count   <= op_count + CNT_W'(1);
            sticky_ovf <= sticky_ovf | alu_overflow;
        end
    end

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed bench for alu_sequencer, closed-loop with a behavioural 4-bit ALU.
module tb_alu_sequencer;
    import alu_pkg::*;

    localparam int CNT_W = 8;

    logic             clk;
    logic             rst_n;
    logic             cmd_valid;
    logic             cmd_ready;
    logic [2:0]       cmd_op;
    logic             cmd_c;
    logic [3:0]       cmd_x;
    logic [3:0]       cmd_y;
    logic [2:0]       alu_select;
    logic             alu_in_c;
    logic [3:0]       alu_in_x;
    logic [3:0]       alu_in_y;
    logic [3:0]       alu_out_s;
    logic             alu_out_c;
    logic             alu_overflow;
    logic             rsp_valid;
    logic             rsp_ready;
    logic [3:0]       rsp_s;
    logic             rsp_c;
    logic             rsp_zero;
    logic             rsp_ovf;
    logic             rsp_err;
    logic             clr;
    logic             sticky_ovf;
    logic [CNT_W-1:0] op_count;
    state_t           state;

    int checks = 0;
    int errors = 0;

    alu_sequencer #(.CNT_W(CNT_W)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .cmd_op       (cmd_op),
        .cmd_c        (cmd_c),
        .cmd_x        (cmd_x),
        .cmd_y        (cmd_y),
        .alu_select   (alu_select),
        .alu_in_c     (alu_in_c),
        .alu_in_x     (alu_in_x),
        .alu_in_y     (alu_in_y),
        .alu_out_s    (alu_out_s),
        .alu_out_c    (alu_out_c),
        .alu_overflow (alu_overflow),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_s        (rsp_s),
        .rsp_c        (rsp_c),
        .rsp_zero     (rsp_zero),
        .rsp_ovf      (rsp_ovf),
        .rsp_err      (rsp_err),
        .clr          (clr),
        .sticky_ovf   (sticky_ovf),
        .op_count     (op_count),
        .state        (state)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural ALU; the illegal code produces junk so the sequencer must ignore it.
    logic [4:0] sum;
    always_comb begin
        sum          = 5'h00;
        alu_out_s    = 4'h0;
        alu_out_c    = 1'b0;
        alu_overflow = 1'b0;
        case (alu_select)
            OP_ADD: begin
                sum          = {1'b0, alu_in_x} + {1'b0, alu_in_y} + {4'h0, alu_in_c};
                alu_out_s    = sum[3:0];
                alu_out_c    = sum[4];
                alu_overflow = (alu_in_x[3] == alu_in_y[3]) && (sum[3] != alu_in_x[3]);
            end
            OP_SUB, OP_CMP: begin
                sum          = {1'b0, alu_in_x} + {1'b0, ~alu_in_y} + {4'h0, alu_in_c};
                alu_out_s    = sum[3:0];
                alu_out_c    = sum[4];
                alu_overflow = (alu_in_x[3] != alu_in_y[3]) && (sum[3] != alu_in_x[3]);
            end
            OP_NOT: alu_out_s = ~alu_in_x;
            OP_AND: alu_out_s = alu_in_x & alu_in_y;
            OP_OR:  alu_out_s = alu_in_x | alu_in_y;
            OP_XOR: alu_out_s = alu_in_x ^ alu_in_y;
            default: begin
                alu_out_s    = 4'hA;
                alu_out_c    = 1'b1;
                alu_overflow = 1'b1;
            end
        endcase
    end

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic offer(input logic [2:0] op, input logic c, input logic [3:0] x, input logic [3:0] y);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_c     = c;
        cmd_x     = x;
        cmd_y     = y;
    endtask

    task automatic check_rsp(input string tag, input logic [3:0] s, input logic c,
                             input logic zero, input logic ovf, input logic err);
        check({tag, "_valid"}, 32'(rsp_valid), 32'd1);
        check({tag, "_s"},     32'(rsp_s),     32'(s));
        check({tag, "_c"},     32'(rsp_c),     32'(c));
        check({tag, "_zero"},  32'(rsp_zero),  32'(zero));
        check({tag, "_ovf"},   32'(rsp_ovf),   32'(ovf));
        check({tag, "_err"},   32'(rsp_err),   32'(err));
    endtask

    initial begin
        rst_n     = 1'b0;
        cmd_valid = 1'b0;
        cmd_op    = 3'b000;
        cmd_c     = 1'b0;
        cmd_x     = 4'h0;
        cmd_y     = 4'h0;
        rsp_ready = 1'b0;
        clr       = 1'b0;

        // Reset values
        tick();
        tick();
        check("rst_state",     32'(state),      32'(ST_IDLE));
        check("rst_cmd_ready", 32'(cmd_ready),  32'd1);
        check("rst_rsp_valid", 32'(rsp_valid),  32'd0);
        check("rst_rsp_s",     32'(rsp_s),      32'd0);
        check("rst_rsp_err",   32'(rsp_err),    32'd0);
        check("rst_alu_sel",   32'(alu_select), 32'd0);
        check("rst_alu_x",     32'(alu_in_x),   32'd0);
        check("rst_sticky",    32'(sticky_ovf), 32'd0);
        check("rst_count",     32'(op_count),   32'd0);
        rst_n = 1'b1;

        // ADD 7+1: overflow into 8
        offer(OP_ADD, 1'b0, 4'h7, 4'h1);
        tick();
        check("add_state_exec", 32'(state),     32'(ST_EXEC));
        check("add_cmd_ready",  32'(cmd_ready), 32'd0);
        check("add_rsp_early",  32'(rsp_valid), 32'd0);
        check("add_alu_x",      32'(alu_in_x),  32'h7);
        check("add_alu_y",      32'(alu_in_y),  32'h1);
        cmd_valid = 1'b0;
        tick();
        check_rsp("add", 4'h8, 1'b0, 1'b0, 1'b1, 1'b0);
        check("add_sticky", 32'(sticky_ovf), 32'd1);
        check("add_count",  32'(op_count),   32'd1);

        // Consume while a SUB is already offered: must not be taken this edge
        rsp_ready = 1'b1;
        offer(OP_SUB, 1'b1, 4'h5, 4'h5);
        tick();
        check("add_done_state", 32'(state),      32'(ST_IDLE));
        check("add_done_valid", 32'(rsp_valid),  32'd0);
        check("no_same_accept", 32'(alu_select), 32'(OP_ADD));
        rsp_ready = 1'b0;

        // SUB 5-5 with c=1: zero result, carry out
        tick();
        check("sub_state_exec", 32'(state), 32'(ST_EXEC));
        cmd_valid = 1'b0;
        tick();
        check_rsp("sub", 4'h0, 1'b1, 1'b1, 1'b0, 1'b0);
        check("sub_count", 32'(op_count), 32'd2);

        // Back-pressure for three cycles with an AND waiting
        offer(OP_AND, 1'b0, 4'hC, 4'hA);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("hold_state",     32'(state),     32'(ST_RESP));
            check("hold_cmd_ready", 32'(cmd_ready), 32'd0);
            check_rsp("hold", 4'h0, 1'b1, 1'b1, 1'b0, 1'b0);
        end
        rsp_ready = 1'b1;
        tick();
        check("hold_release_state", 32'(state), 32'(ST_IDLE));
        rsp_ready = 1'b0;
        tick();
        check("and_state_exec", 32'(state),      32'(ST_EXEC));
        check("and_alu_sel",    32'(alu_select), 32'(OP_AND));
        cmd_valid = 1'b0;
        tick();
        check_rsp("and", 4'h8, 1'b0, 1'b0, 1'b0, 1'b0);
        check("and_count",  32'(op_count),   32'd3);
        check("and_sticky", 32'(sticky_ovf), 32'd1);
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;

        // Illegal op: error response, ALU junk ignored, no count
        offer(OP_ILLEGAL, 1'b0, 4'h3, 4'h4);
        tick();
        cmd_valid = 1'b0;
        tick();
        check_rsp("ill", 4'h0, 1'b0, 1'b0, 1'b0, 1'b1);
        check("ill_count", 32'(op_count), 32'd3);
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        tick();
        check("ill_alu_sel_held", 32'(alu_select), 32'(OP_ILLEGAL));
        check("ill_alu_x_held",   32'(alu_in_x),   32'h3);

        // clr on the EXEC->RESP edge of an overflowing ADD 4+4
        offer(OP_ADD, 1'b0, 4'h4, 4'h4);
        tick();
        cmd_valid = 1'b0;
        clr       = 1'b1;
        tick();
        clr = 1'b0;
        check_rsp("clr_add", 4'h8, 1'b0, 1'b0, 1'b1, 1'b0);
        check("clr_count",  32'(op_count),   32'd0);
        check("clr_sticky", 32'(sticky_ovf), 32'd0);
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;

        // CMP 2 vs 3 with c=1: counting resumes, no overflow
        offer(OP_CMP, 1'b1, 4'h2, 4'h3);
        tick();
        cmd_valid = 1'b0;
        tick();
        check_rsp("cmp", 4'hF, 1'b0, 1'b0, 1'b0, 1'b0);
        check("cmp_count",  32'(op_count),   32'd1);
        check("cmp_sticky", 32'(sticky_ovf), 32'd0);
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;

        // Reset asserted mid-EXEC
        offer(OP_ADD, 1'b0, 4'h7, 4'h7);
        tick();
        cmd_valid = 1'b0;
        check("rx_state_exec", 32'(state), 32'(ST_EXEC));
        #2;
        rst_n = 1'b0;
        #1;
        check("rx_rsp_valid", 32'(rsp_valid),  32'd0);
        check("rx_cmd_ready", 32'(cmd_ready),  32'd1);
        check("rx_alu_sel",   32'(alu_select), 32'd0);
        check("rx_alu_x",     32'(alu_in_x),   32'd0);
        check("rx_alu_y",     32'(alu_in_y),   32'd0);
        check("rx_count",     32'(op_count),   32'd0);
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("rx_no_rsp",   32'(rsp_valid), 32'd0);
            check("rx_idle",     32'(state),     32'(ST_IDLE));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
